// File: rtl/boton_eventos.sv
// Push-button event decoder: turns a debounced button level into press/release
// edges plus short, long, double-click and auto-repeat strobes.
module boton_eventos #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_evt,
  output logic long_evt,
  output logic double_evt,
  output logic repeat_evt
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_REL  = 3'd0,
    IDLE      = 3'd1,
    PRESS1    = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4,
    LONG_HOLD = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  logic             press_d, release_d, short_d, long_d, double_d, repeat_d;

  // State, counter, edge register and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= WAIT_REL;
      cnt_q         <= '0;
      btn_q         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_evt     <= 1'b0;
      long_evt      <= 1'b0;
      double_evt    <= 1'b0;
      repeat_evt    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_q         <= btn_db;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_evt     <= short_d;
      long_evt      <= long_d;
      double_evt    <= double_d;
      repeat_evt    <= repeat_d;
    end
  end

  // Next state and counter; an edge on btn_db always beats a terminal count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_REL: begin
        if (!btn_db) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (btn_db) state_d = PRESS1;
      end
      PRESS1: begin
        if (!btn_db) begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG_HOLD: begin
        if (!btn_db) state_d = IDLE;
        else if (cnt_q == REPEAT_LAST) cnt_d = '0;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      WAIT_GAP: begin
        if (btn_db) state_d = PRESS2;
        else if (cnt_q == GAP_LAST) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      PRESS2: begin
        if (!btn_db) state_d = IDLE;
      end
      default: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobe decode, registered above
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    repeat_d  = 1'b0;
    if (state_q != WAIT_REL) begin
      press_d   = btn_db & ~btn_q;
      release_d = ~btn_db & btn_q;
    end
    unique case (state_q)
      PRESS1:    long_d   = btn_db && (cnt_q == LONG_LAST);
      LONG_HOLD: repeat_d = btn_db && (cnt_q == REPEAT_LAST);
      WAIT_GAP: begin
        double_d = btn_db;
        short_d  = !btn_db && (cnt_q == GAP_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos with short timing parameters.
module tb_boton_eventos;

  localparam int unsigned LONG_C = 20;
  localparam int unsigned GAP_C  = 10;
  localparam int unsigned REP_C  = 5;

  // Output bitmap: {press, release, short, long, double, repeat}
  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] P  = 6'b100000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] S  = 6'b001000;
  localparam logic [5:0] L  = 6'b000100;
  localparam logic [5:0] D  = 6'b000010;
  localparam logic [5:0] RP = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_db = 1'b0;
  logic press_pulse, release_pulse, short_evt, long_evt, double_evt, repeat_evt;
  logic [5:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        btn;
    int unsigned rep;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  boton_eventos #(
    .LONG_CYCLES  (LONG_C),
    .GAP_CYCLES   (GAP_C),
    .REPEAT_CYCLES(REP_C),
    .CNT_W        (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_db       (btn_db),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_evt    (short_evt),
    .long_evt     (long_evt),
    .double_evt   (double_evt),
    .repeat_evt   (repeat_evt)
  );

  assign outs = {press_pulse, release_pulse, short_evt, long_evt, double_evt, repeat_evt};

  always #5 clk = ~clk;

  function automatic void add(input logic b, input int unsigned r, input logic [5:0] e);
    vec_t v;
    v.btn = b;
    v.rep = r;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive btn on the falling edge, check outputs 1 time unit after the rising edge
  task automatic step(input logic b, input logic [5:0] exp, input string name);
    @(negedge clk);
    btn_db = b;
    @(posedge clk);
    #1;
    check(name, outs, exp);
  endtask

  task automatic run_seg(input logic b, input int unsigned n, input logic [5:0] exp, input string name);
    for (int k = 0; k < int'(n); k++) step(b, exp, name);
  endtask

  initial begin
    // Reset state with button released
    rst    = 1'b0;
    btn_db = 1'b0;
    #23;
    check("reset_outs", outs, NO);
    @(negedge clk);
    rst = 1'b1;

    // First edge leaves WAIT_REL silently
    add(0, 1, NO);
    add(0, 3, NO);
    // Short press: 5 cycles, short_evt 10 cycles after release edge
    add(1, 1, P);  add(1, 4, NO);
    add(0, 1, R);  add(0, 9, NO);  add(0, 1, S);  add(0, 5, NO);
    // Long press with auto-repeat at 25..45, release yields no short
    add(1, 1, P);  add(1, 19, NO); add(1, 1, L);
    for (int k = 0; k < 5; k++) begin
      add(1, 4, NO); add(1, 1, RP);
    end
    add(0, 1, R);  add(0, 15, NO);
    // Double click, then 30 quiet cycles
    add(1, 1, P);  add(1, 3, NO);
    add(0, 1, R);  add(0, 2, NO);
    add(1, 1, P | D); add(1, 3, NO);
    add(0, 1, R);  add(0, 30, NO);
    // Release exactly at the long-press decision edge: short path wins
    add(1, 1, P);  add(1, 19, NO);
    add(0, 1, R);  add(0, 9, NO);  add(0, 1, S);  add(0, 3, NO);
    // Re-press exactly at the gap decision edge, then hold long in PRESS2
    add(1, 1, P);  add(1, 2, NO);
    add(0, 1, R);  add(0, 9, NO);
    add(1, 1, P | D); add(1, 25, NO);
    add(0, 1, R);  add(0, 12, NO);

    foreach (vecs[i]) run_seg(vecs[i].btn, vecs[i].rep, vecs[i].exp, $sformatf("vec%0d", i));

    // Button held through reset release: silent until release then a new press
    @(negedge clk);
    btn_db = 1'b1;
    rst    = 1'b0;
    #1;
    check("held_in_reset", outs, NO);
    @(negedge clk);
    rst = 1'b1;
    run_seg(1, 30, NO, "held_after_reset");
    step(0, NO, "held_first_release");
    run_seg(0, 2, NO, "held_idle");
    step(1, P, "held_new_press");
    run_seg(1, 2, NO, "held_press_hold");
    step(0, R, "held_release");
    run_seg(0, 9, NO, "held_gap");
    step(0, S, "held_short");

    // Reset during WAIT_GAP: strobes drop at once, pending short discarded
    run_seg(0, 3, NO, "gap_idle");
    step(1, P, "gap_press");
    run_seg(1, 2, NO, "gap_hold");
    step(0, R, "gap_release");
    #1;
    rst = 1'b0;
    #1;
    check("gap_reset_async", outs, NO);
    run_seg(0, 3, NO, "gap_in_reset");
    @(negedge clk);
    rst = 1'b1;
    run_seg(0, 20, NO, "gap_no_short");
    step(1, P, "gap_restart_press");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boton_eventos.md
# boton_eventos

Push-button event decoder sitting downstream of the `antirebote` debouncer. It consumes the clean, debounced button level and classifies each press as a short press, a long press or a double click. It also emits auto-repeat ticks while a long press is held. All outputs are single-cycle, registered strobes intended for menu/control FSMs elsewhere in the design.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time that qualifies a long press (0.5 s at 10 ns clock).
- `GAP_CYCLES`, default 25_000_000: maximum release-to-press gap for a double click.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period after a long press.
- `CNT_W`, default 26: counter width; must hold max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) − 1.
- `clk`, input, 1: system clock. Everything is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it (0) clears the block immediately; release is sampled on `clk`.
- `btn_db`, input, 1: debounced button level, 1 = pressed. Synchronous to `clk`.
- `press_pulse`, output, 1: one-cycle strobe on each press edge.
- `release_pulse`, output, 1: one-cycle strobe on each release edge.
- `short_evt`, output, 1: one-cycle strobe when a single short press is confirmed.
- `long_evt`, output, 1: one-cycle strobe when the hold reaches `LONG_CYCLES`.
- `double_evt`, output, 1: one-cycle strobe on the second press of a double click.
- `repeat_evt`, output, 1: one-cycle strobe every `REPEAT_CYCLES` while a long press is held.

## Operation
- One edge register `btn_q`, one counter `cnt[CNT_W-1:0]`, and a state register.
- FSM states: WAIT_REL, IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HOLD.
- Reset (rst=0):
  - State goes to WAIT_REL, `btn_q`=1, `cnt`=0.
  - All outputs go to 0.
- WAIT_REL:
  - Moves to IDLE on the first edge with `btn_db`=0.
  - A button held through reset release therefore produces no event.
- IDLE: `btn_db`=1 → PRESS1, `cnt`←0.
- PRESS1:
  - `btn_db`=0 → WAIT_GAP, `cnt`←0.
  - Otherwise, if `cnt`==LONG_CYCLES−1 → `long_evt`, then LONG_HOLD, `cnt`←0.
  - Otherwise `cnt`++.
- LONG_HOLD:
  - `btn_db`=0 → IDLE.
  - Otherwise, if `cnt`==REPEAT_CYCLES−1 → `repeat_evt`, `cnt`←0.
  - Otherwise `cnt`++.
- WAIT_GAP:
  - `btn_db`=1 → `double_evt`, then PRESS2.
  - Otherwise, if `cnt`==GAP_CYCLES−1 → `short_evt`, then IDLE.
  - Otherwise `cnt`++.
- PRESS2:
  - `btn_db`=0 → IDLE.
  - No long-press detection during the second press.
- Edge strobes:
  - `press_pulse` = `btn_db` & ~`btn_q`; `release_pulse` = ~`btn_db` & `btn_q`. Both are registered.
  - Both are suppressed while the state is WAIT_REL.
  - `btn_q`←`btn_db` every cycle.
- Mutual exclusion: `short_evt`, `long_evt`, `double_evt` and `repeat_evt` never coincide. Edge strobes may coincide with them.
- Counter arithmetic is unsigned and never wraps: it is always cleared before reaching its terminal value + 1.

## Timing
- All outputs are registered. A condition sampled at edge N drives its strobe high from N to N+1.
- `press_pulse`/`release_pulse`: high in the cycle after the first edge that samples the new `btn_db` level.
- `long_evt`: fires at the edge exactly LONG_CYCLES cycles after the edge that entered PRESS1.
- `short_evt`: fires GAP_CYCLES cycles after the edge that entered WAIT_GAP.
- `double_evt`: fires at the first edge sampling `btn_db`=1 in WAIT_GAP.
- `repeat_evt`: first strobe REPEAT_CYCLES cycles after `long_evt`, then periodic with period REPEAT_CYCLES.
- Simultaneous events at a decision edge:
  - Release at the same edge where PRESS1 `cnt`==LONG_CYCLES−1: release wins, giving WAIT_GAP and no `long_evt`.
  - Press at the same edge where WAIT_GAP `cnt`==GAP_CYCLES−1: press wins, giving `double_evt` and no `short_evt`.
- Reset asserted mid-operation: outputs drop to 0 asynchronously, any pending short/long/double decision is discarded, and the block restarts in WAIT_REL.

## Test plan
Use LONG_CYCLES=20, GAP_CYCLES=10, REPEAT_CYCLES=5, with `btn_db` driven on clock edges.
- Press for 5 cycles, then release and hold low: `press_pulse`, then `release_pulse`, then exactly one `short_evt` 10 cycles after the release edge. No other events.
- Press for 45 cycles: `long_evt` at cycle 20 after the press edge, then `repeat_evt` at 25, 30, 35, 40, 45. On release: `release_pulse` only, no `short_evt`.
- Press 4 cycles, release 3 cycles, press 4 cycles, release: `double_evt` on the second press edge. No `short_evt` and no `long_evt`, including 30 cycles after.
- Release at exactly cycle 20 of PRESS1, and in a separate run re-press at exactly cycle 10 of WAIT_GAP: respectively no `long_evt` with the short path taken, and `double_evt` without `short_evt`.
- Reset both ways:
  - Hold `btn_db`=1 through reset release for 30 cycles: no strobes until a release followed by a new press.
  - Assert rst=0 during WAIT_GAP: all outputs 0 immediately and no `short_evt` afterward.
